// File: rtl/wb_mux_pipe.sv
// Registered N-to-1 writeback selector with valid/ready handshake and out-of-range select flagging.
// Define WB_MUX_SKID_EN for the two-entry skid build with a registered in_ready.
module wb_mux_pipe #(
    parameter int DWIDTH = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_sel_err,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Returns {err, data}; an unmatched select yields an all-zero word with err set.
    function automatic logic [DWIDTH:0] select_word(
        input logic [NUM_IN*DWIDTH-1:0] data,
        input logic [SEL_W-1:0]         s
    );
        logic [DWIDTH:0] w;
        w = {1'b1, {DWIDTH{1'b0}}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (s == k[SEL_W-1:0]) begin
                w = {1'b0, data[k*DWIDTH +: DWIDTH]};
            end
        end
        return w;
    endfunction

    logic [DWIDTH:0]   cap_word;
    logic              in_xfer;
    logic              out_xfer;
    logic [DWIDTH-1:0] data_p0;
    logic              err_p0;
    logic              vld_p0;

    assign cap_word    = select_word(in_data, sel);
    assign in_xfer     = in_valid & in_ready;
    assign out_xfer    = vld_p0 & out_ready;
    assign out_data    = data_p0;
    assign out_sel_err = err_p0;
    assign out_valid   = vld_p0;

`ifdef WB_MUX_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DWIDTH-1:0] data_p1;
    logic              err_p1;
    logic              rdy_q;

    assign in_ready = rdy_q;

    // Stage p0 is the main output register, p1 the skid entry behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            data_p0 <= '0;
            err_p0  <= 1'b0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
            vld_p0  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        data_p0 <= cap_word[DWIDTH-1:0];
                        err_p0  <= cap_word[DWIDTH];
                        vld_p0  <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        data_p0 <= cap_word[DWIDTH-1:0];
                        err_p0  <= cap_word[DWIDTH];
                    end else if (in_xfer) begin
                        data_p1 <= cap_word[DWIDTH-1:0];
                        err_p1  <= cap_word[DWIDTH];
                        rdy_q   <= 1'b0;
                        state   <= TWO;
                    end else if (out_xfer) begin
                        vld_p0  <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        data_p0 <= data_p1;
                        err_p0  <= err_p1;
                        rdy_q   <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    vld_p0 <= 1'b0;
                    rdy_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    // A departing word frees the register in the same edge, so ready looks through to out_ready.
    assign in_ready = ~vld_p0 | out_ready;

    // Stage p0: single output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            err_p0  <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (in_xfer) begin
            data_p0 <= cap_word[DWIDTH-1:0];
            err_p0  <= cap_word[DWIDTH];
            vld_p0  <= 1'b1;
        end else if (out_xfer) begin
            vld_p0  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Bench for wb_mux_pipe: three parameterisations checked each cycle against a FIFO-occupancy model.
module tb_wb_mux_pipe;

`ifdef WB_MUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: DWIDTH=32, NUM_IN=4
    logic [127:0] a_in_data = '0;
    logic [1:0]   a_sel = '0;
    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_err;
    logic [31:0]  a_out_data;
    // Instance B: DWIDTH=32, NUM_IN=5
    logic [159:0] b_in_data = '0;
    logic [2:0]   b_sel = '0;
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_err;
    logic [31:0]  b_out_data;
    // Instance C: DWIDTH=8, NUM_IN=2
    logic [15:0]  c_in_data = '0;
    logic [0:0]   c_sel = '0;
    logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_err;
    logic [7:0]   c_out_data;

    wb_mux_pipe #(.DWIDTH(32), .NUM_IN(4)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_sel_err(a_err),
        .out_valid(a_out_valid), .out_ready(a_out_ready));
    wb_mux_pipe #(.DWIDTH(32), .NUM_IN(5)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_sel_err(b_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready));
    wb_mux_pipe #(.DWIDTH(8), .NUM_IN(2)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_sel_err(c_err),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] mq [3][$];
    logic [31:0] alog [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {err, data} of whatever each instance would capture this cycle.
    function automatic logic [32:0] word_a();
        int idx = int'(a_sel);
        return {1'b0, a_in_data[idx*32 +: 32]};
    endfunction
    function automatic logic [32:0] word_b();
        int idx = int'(b_sel);
        if (idx < 5) return {1'b0, b_in_data[idx*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction
    function automatic logic [32:0] word_c();
        int idx = int'(c_sel);
        return {25'h0, c_in_data[idx*8 +: 8]};
    endfunction

    // The block behaves as a FIFO of depth 2 (skid) or 1 whose head is visible on the outputs.
    task automatic model_step(input int id, input string nm, input logic ov, input logic [31:0] od,
                              input logic oe, input logic ir, input logic ordy, input logic iv,
                              input logic [32:0] w);
        logic exp_vld, exp_rdy;
        exp_vld = mq[id].size() > 0;
        check({nm, ".out_valid"}, 64'(ov), 64'(exp_vld));
        if (exp_vld) begin
            check({nm, ".out_data"}, 64'(od), 64'(mq[id][0][31:0]));
            check({nm, ".out_sel_err"}, 64'(oe), 64'(mq[id][0][32]));
        end
        exp_rdy = SKID ? (mq[id].size() < 2) : (!exp_vld || ordy);
        check({nm, ".in_ready"}, 64'(ir), 64'(exp_rdy));
        if (ov && ordy && mq[id].size() > 0) begin
            if (id == 0) alog.push_back(od);
            void'(mq[id].pop_front());
        end
        if (iv && ir) mq[id].push_back(w);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst.a_out_valid", 64'(a_out_valid), 64'd0);
            check("rst.a_out_data", 64'(a_out_data), 64'd0);
            check("rst.a_err", 64'(a_err), 64'd0);
            check("rst.a_in_ready", 64'(a_in_ready), 64'd1);
            check("rst.b_out_valid", 64'(b_out_valid), 64'd0);
            check("rst.c_out_valid", 64'(c_out_valid), 64'd0);
            for (int i = 0; i < 3; i++) mq[i].delete();
        end else begin
            model_step(0, "A", a_out_valid, a_out_data, a_err, a_in_ready, a_out_ready, a_in_valid, word_a());
            model_step(1, "B", b_out_valid, b_out_data, b_err, b_in_ready, b_out_ready, b_in_valid, word_b());
            model_step(2, "C", c_out_valid, {24'h0, c_out_data}, c_err, c_in_ready, c_out_ready, c_in_valid, word_c());
        end
    end

    initial begin
        logic [31:0] exp_b [4];
        logic [2:0]  sel_b [4];
        int idx;
        int nout;
        logic acc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Select sweep on A: input k holds k+1
        a_in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            a_in_valid = 1'b1;
            @(posedge clk); #1;
            check("sweep.data", 64'(a_out_data), 64'(i + 1));
            check("sweep.valid", 64'(a_out_valid), 64'd1);
            check("sweep.err", 64'(a_err), 64'd0);
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("sweep.drained", 64'(a_out_valid), 64'd0);

        // Out-of-range selects on B: input k holds 100+k
        b_in_data = {32'd104, 32'd103, 32'd102, 32'd101, 32'd100};
        b_out_ready = 1'b1;
        sel_b = '{3'd5, 3'd6, 3'd7, 3'd4};
        exp_b = '{32'd0, 32'd0, 32'd0, 32'd104};
        for (int i = 0; i < 4; i++) begin
            b_sel = sel_b[i];
            b_in_valid = 1'b1;
            @(posedge clk); #1;
            check("oor.data", 64'(b_out_data), 64'(exp_b[i]));
            check("oor.err", 64'(b_err), (i < 3) ? 64'd1 : 64'd0);
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure on A: words 10..13, out_ready low for 4 cycles after the first appears
        alog.delete();
        a_sel = 2'd0;
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            a_out_ready = !(cyc >= 1 && cyc <= 4);
            a_in_valid = (idx < 4);
            a_in_data[31:0] = 32'(10 + idx);
            @(negedge clk);
            if (cyc == 1) check("bp.ready_c1", 64'(a_in_ready), SKID ? 64'd1 : 64'd0);
            if (cyc == 2) check("bp.ready_c2", 64'(a_in_ready), 64'd0);
            if (cyc >= 1 && cyc <= 4) check("bp.stable", 64'(a_out_data), 64'd10);
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        a_in_valid = 1'b0;
        check("bp.count", 64'(alog.size()), 64'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++) check("bp.order", 64'(alog[i]), 64'(10 + i));

        // Simultaneous transfer: 16 words back to back
        a_out_ready = 1'b1;
        nout = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            a_in_valid = (cyc < 16);
            a_sel = 2'($urandom_range(0, 3));
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (a_out_valid && a_out_ready) nout++;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        check("stream.outputs", 64'(nout), 64'd16);

        // Mid-stream reset while A holds words
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) mq[i].delete();
        #1;
        check("mrst.valid", 64'(a_out_valid), 64'd0);
        check("mrst.data", 64'(a_out_data), 64'd0);
        check("mrst.ready", 64'(a_in_ready), 64'd1);
        #1 rst = 1'b0;
        a_sel = 2'd0;
        a_in_data[31:0] = 32'd7;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("mrst.next_data", 64'(a_out_data), 64'd7);
        check("mrst.next_valid", 64'(a_out_valid), 64'd1);

        // Width parameterisation on C
        c_in_data = 16'h5AA5;
        c_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_sel = 1'(i % 2);
            c_in_valid = 1'b1;
            @(posedge clk); #1;
            check("width.data", 64'(c_out_data), (i % 2) ? 64'h5A : 64'hA5);
            check("width.err", 64'(c_err), 64'd0);
        end
        c_in_valid = 1'b0;

        // Randomised traffic on all three instances
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_in_valid = 1'($urandom_range(0, 3) != 0);
            a_out_ready = 1'($urandom_range(0, 2) != 0);
            a_sel = 2'($urandom_range(0, 3));
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            b_in_valid = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_sel = 3'($urandom_range(0, 7));
            b_in_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            c_in_valid = 1'($urandom_range(0, 1));
            c_out_ready = 1'($urandom_range(0, 3) != 0);
            c_sel = 1'($urandom_range(0, 1));
            c_in_data = 16'($urandom);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("end.a_empty", 64'(a_out_valid), 64'd0);
        check("end.b_empty", 64'(b_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
